// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I main controller.
package cpu_ctrl_pkg;

  // Controller states; codes 10-15 are unused and recover to S_FAULT.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8,
    S_FAULT    = 4'd9
  } state_t;

  // Supported RV32I major opcodes.
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_IALU = 7'b0010011;

  // ALUOp encodings seen by the ALU control decoder.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory wait cycles within one state and flags the limit.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic clear,
  output logic expired
);

  logic [TMO_W-1:0] cnt;

  // Clear wins over counting so every state starts its wait budget at zero.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (waiting) begin
      cnt <= cnt + 1'b1;
    end
  end

  // A limit of zero disables the timeout entirely.
  assign expired = (MEM_TIMEOUT != 0) && (cnt == TMO_W'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I main controller: sequences FETCH..WRITEBACK and drives
// datapath controls. Memory handshake: a request is outstanding while mem_req
// is high; the cycle with mem_req && mem_ready completes it, and the FSM
// leaves the handshake state on exactly that cycle.
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int OPC_W       = 7,
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPC_W-1:0] opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_req,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             ALUSrc,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             Branch,
  output logic [1:0]       ALUOp,
  output logic [3:0]       state_o,
  output logic             illegal,
  output logic             timeout,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired
);

  state_t           state, state_nx;
  logic [OPC_W-1:0] opc_q;
  logic             set_illegal, set_timeout;
  logic             waiting, expired, clear;

  // Wait cycles are only counted while a request is outstanding and unanswered.
  assign waiting = mem_req && !mem_ready;
  assign clear   = (state_nx != state);

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TMO_W       (TMO_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .waiting (waiting),
    .clear   (clear),
    .expired (expired)
  );

  // Next-state and Moore outputs; mem_ready only gates the completion pulses.
  always_comb begin
    state_nx    = state;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    mem_req     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    ALUSrc      = 1'b0;
    MemToReg    = 1'b0;
    RegWrite    = 1'b0;
    Branch      = 1'b0;
    ALUOp       = ALUOP_ADD;
    instr_done  = 1'b0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        if (mem_ready) begin
          pc_write = 1'b1;
          ir_write = 1'b1;
          state_nx = S_DECODE;
        end else if (expired) begin
          set_timeout = 1'b1;
          state_nx    = S_FAULT;
        end
      end
      S_DECODE: begin
        if (opcode == OP_LW || opcode == OP_SW) begin
          state_nx = S_MEM_ADDR;
        end else if (opcode == OP_R || opcode == OP_IALU) begin
          state_nx = S_EXEC;
        end else if (opcode == OP_BEQ) begin
          state_nx = S_BRANCH;
        end else begin
          set_illegal = 1'b1;
          state_nx    = S_FAULT;
        end
      end
      S_MEM_ADDR: begin
        ALUSrc   = 1'b1;
        state_nx = (opc_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        ALUSrc  = 1'b1;
        if (mem_ready) begin
          state_nx = S_MEM_WB;
        end else if (expired) begin
          set_timeout = 1'b1;
          state_nx    = S_FAULT;
        end
      end
      S_MEM_WB: begin
        RegWrite   = 1'b1;
        MemToReg   = 1'b1;
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        ALUSrc   = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_nx   = S_FETCH;
        end else if (expired) begin
          set_timeout = 1'b1;
          state_nx    = S_FAULT;
        end
      end
      S_EXEC: begin
        ALUOp    = ALUOP_FUNCT;
        ALUSrc   = (opc_q == OP_IALU);
        state_nx = S_ALU_WB;
      end
      S_ALU_WB: begin
        RegWrite   = 1'b1;
        ALUOp      = ALUOP_FUNCT;
        ALUSrc     = (opc_q == OP_IALU);
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      S_BRANCH: begin
        Branch     = 1'b1;
        ALUOp      = ALUOP_SUB;
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      default: begin
        state_nx = S_FAULT;
      end
    endcase
  end

  // State, latched opcode, sticky fault flags and retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      opc_q   <= '0;
      illegal <= 1'b0;
      timeout <= 1'b0;
      retired <= '0;
    end else begin
      state <= state_nx;
      if (state == S_DECODE) opc_q <= opcode;
      if (set_illegal) illegal <= 1'b1;
      if (set_timeout) timeout <= 1'b1;
      if (instr_done) retired <= retired + 1'b1;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed and randomized bench for multicycle_control: each instruction is
// expanded into its expected per-cycle trace from the opcode class and the
// chosen memory wait counts, then replayed against the DUT.
module tb_multicycle_control;

  localparam int CNT_W = 4;
  localparam int LIMIT = 15;

  // Expected control vector bit positions.
  localparam logic [11:0] C_REQ  = 12'h800;
  localparam logic [11:0] C_RD   = 12'h400;
  localparam logic [11:0] C_WR   = 12'h200;
  localparam logic [11:0] C_SRC  = 12'h100;
  localparam logic [11:0] C_M2R  = 12'h080;
  localparam logic [11:0] C_RW   = 12'h040;
  localparam logic [11:0] C_BR   = 12'h020;
  localparam logic [11:0] C_OPF  = 12'h010;
  localparam logic [11:0] C_OPS  = 12'h008;
  localparam logic [11:0] C_PCW  = 12'h004;
  localparam logic [11:0] C_IRW  = 12'h002;
  localparam logic [11:0] C_DONE = 12'h001;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IA = 7'b0010011, BQ = 7'b1100011, BAD = 7'b1111111;

  logic             clk = 1'b0;
  logic             reset;
  logic [6:0]       opcode;
  logic             mem_ready;
  logic             pc_write, ir_write, mem_req, MemRead, MemWrite;
  logic             ALUSrc, MemToReg, RegWrite, Branch;
  logic [1:0]       ALUOp;
  logic [3:0]       state_o;
  logic             illegal, timeout, instr_done;
  logic [CNT_W-1:0] retired;

  int errors = 0;
  int checks = 0;
  logic [CNT_W-1:0] exp_retired;
  logic             exp_illegal, exp_timeout;

  multicycle_control #(
    .OPC_W (7), .MEM_TIMEOUT (LIMIT), .TMO_W (4), .CNT_W (CNT_W)
  ) dut (
    .clk (clk), .reset (reset), .opcode (opcode), .mem_ready (mem_ready),
    .pc_write (pc_write), .ir_write (ir_write), .mem_req (mem_req),
    .MemRead (MemRead), .MemWrite (MemWrite), .ALUSrc (ALUSrc),
    .MemToReg (MemToReg), .RegWrite (RegWrite), .Branch (Branch),
    .ALUOp (ALUOp), .state_o (state_o), .illegal (illegal),
    .timeout (timeout), .instr_done (instr_done), .retired (retired)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge: drive inputs, check, move to next falling edge.
  task automatic step(input logic [3:0] st, input logic [11:0] ctl, input logic rdy,
                      input logic [6:0] op);
    logic [11:0] got;
    mem_ready = rdy;
    opcode    = op;
    #1;
    got = {mem_req, MemRead, MemWrite, ALUSrc, MemToReg, RegWrite, Branch,
           ALUOp, pc_write, ir_write, instr_done};
    chk("state", 32'(state_o), 32'(st));
    chk("ctrl", 32'(got), 32'(ctl));
    chk("retired", 32'(retired), 32'(exp_retired));
    chk("illegal", 32'(illegal), 32'(exp_illegal));
    chk("timeout", 32'(timeout), 32'(exp_timeout));
    if (ctl[0]) exp_retired = exp_retired + 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    mem_ready = 1'($urandom_range(0, 1));
    opcode    = 7'($urandom);
    repeat (2) @(negedge clk);
    reset       = 1'b0;
    exp_retired = '0;
    exp_illegal = 1'b0;
    exp_timeout = 1'b0;
  endtask

  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction

  function automatic logic rrdy();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected trace of one instruction with wf fetch waits and wm data waits.
  task automatic run_instr(input logic [6:0] op, input int wf, input int wm);
    logic [11:0] src;
    for (int i = 0; i < wf; i++) step(4'd0, C_REQ | C_RD, 1'b0, rop());
    step(4'd0, C_REQ | C_RD | C_PCW | C_IRW, 1'b1, rop());
    step(4'd1, 12'h000, rrdy(), op);
    if (op == LW) begin
      step(4'd2, C_SRC, rrdy(), rop());
      for (int i = 0; i < wm; i++) step(4'd3, C_REQ | C_RD | C_SRC, 1'b0, rop());
      step(4'd3, C_REQ | C_RD | C_SRC, 1'b1, rop());
      step(4'd4, C_RW | C_M2R | C_DONE, rrdy(), rop());
    end else if (op == SW) begin
      step(4'd2, C_SRC, rrdy(), rop());
      for (int i = 0; i < wm; i++) step(4'd5, C_REQ | C_WR | C_SRC, 1'b0, rop());
      step(4'd5, C_REQ | C_WR | C_SRC | C_DONE, 1'b1, rop());
    end else if (op == RT || op == IA) begin
      src = (op == IA) ? C_SRC : 12'h000;
      step(4'd6, C_OPF | src, rrdy(), rop());
      step(4'd7, C_OPF | C_RW | src | C_DONE, rrdy(), rop());
    end else if (op == BQ) begin
      step(4'd8, C_BR | C_OPS | C_DONE, rrdy(), rop());
    end else begin
      exp_illegal = 1'b1;
      for (int i = 0; i < 10; i++) step(4'd9, 12'h000, rrdy(), rop());
      do_reset();
    end
  endtask

  initial begin
    logic [6:0] ops [6];
    logic [6:0] op;
    ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = IA; ops[4] = BQ; ops[5] = BAD;
    reset = 1'b1; mem_ready = 1'b0; opcode = '0;
    exp_retired = '0; exp_illegal = 1'b0; exp_timeout = 1'b0;

    // Reset and zero-wait lw
    do_reset();
    run_instr(LW, 0, 0);
    // sw with three data wait cycles
    run_instr(SW, 0, 3);
    // R-type, addi, beq back to back
    run_instr(RT, 0, 0);
    run_instr(IA, 0, 0);
    run_instr(BQ, 0, 0);
    // Illegal opcode, then reset back to FETCH
    run_instr(BAD, 0, 0);
    step(4'd0, C_REQ | C_RD, 1'b0, rop());

    // Fetch timeout: limit reached with ready low goes to FAULT
    do_reset();
    for (int i = 0; i <= LIMIT; i++) step(4'd0, C_REQ | C_RD, 1'b0, rop());
    exp_timeout = 1'b1;
    for (int i = 0; i < 4; i++) step(4'd9, 12'h000, rrdy(), rop());

    // Ready on the limit cycle completes normally; wait budget is per state
    do_reset();
    run_instr(BQ, LIMIT, 0);
    run_instr(SW, 0, LIMIT);
    run_instr(LW, 12, 12);

    // Data-read timeout
    step(4'd0, C_REQ | C_RD | C_PCW | C_IRW, 1'b1, rop());
    step(4'd1, 12'h000, rrdy(), LW);
    step(4'd2, C_SRC, rrdy(), rop());
    for (int i = 0; i <= LIMIT; i++) step(4'd3, C_REQ | C_RD | C_SRC, 1'b0, rop());
    exp_timeout = 1'b1;
    step(4'd9, 12'h000, rrdy(), rop());

    // Reset in the middle of an instruction
    do_reset();
    step(4'd0, C_REQ | C_RD | C_PCW | C_IRW, 1'b1, rop());
    step(4'd1, 12'h000, rrdy(), SW);
    step(4'd2, C_SRC, rrdy(), rop());
    do_reset();
    step(4'd0, C_REQ | C_RD, 1'b0, rop());

    // Random instruction stream, long enough to wrap the retire counter
    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 9) == 0) ? ops[5] : ops[$urandom_range(0, 4)];
      run_instr(op, $urandom_range(0, 4), $urandom_range(0, 4));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
